// File: rtl/usb_crc_engine.sv
// usb_crc_engine: serial CRC5/CRC16 engine for the USB bit paths.
// Generate mode passes data bits straight through and then flushes the
// complemented CRC, MSB first. Check mode absorbs data plus the received
// CRC and compares the register against the USB residue.
module usb_crc_engine #(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = 16'h8005,
    parameter logic [WIDTH-1:0] INIT    = 16'hFFFF,
    parameter logic [WIDTH-1:0] RESIDUE = 16'h800D,
    parameter int              CNT_W   = 14
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode_gen,
    input  logic             bit_valid,
    input  logic             in_bit,
    input  logic             data_done,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             result_valid,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             overrun,
    output logic [WIDTH-1:0] crc_value,
    output logic [CNT_W-1:0] bit_count
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] crc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             mode_q;
    logic             overrun_q;

    logic [WIDTH-1:0] crc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             flush_last;

    // One LFSR step: feedback is the incoming bit against the register MSB.
    function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c,
                                                  input logic             b);
        logic fb;
        fb = b ^ c[WIDTH-1];
        return {c[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // Bit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Next register values for a bit accepted this cycle.
    always_comb begin
        crc_d      = crc_step(crc_q, in_bit);
        cnt_d      = sat_inc(cnt_q);
        flush_last = (idx_q == IDX_LAST);
    end

    // Packet sequencer; start always wins and restarts the packet.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            crc_q     <= INIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            mode_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (start) begin
            state_q   <= S_ACCUM;
            crc_q     <= INIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            mode_q    <= mode_gen;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_IDLE;
                end
                S_ACCUM: begin
                    // A bit presented together with data_done is still absorbed.
                    if (bit_valid) begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_d;
                    end
                    if (data_done) begin
                        idx_q   <= '0;
                        state_q <= mode_q ? S_FLUSH : S_DONE;
                    end
                end
                S_FLUSH: begin
                    // The CRC is frozen here; input bits are dropped and flagged.
                    if (bit_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_ready) begin
                        if (flush_last) begin
                            idx_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode; generate-mode data passes through with zero latency.
    always_comb begin
        out_valid = 1'b0;
        out_bit   = 1'b0;
        case (state_q)
            S_ACCUM: begin
                if (mode_q) begin
                    out_valid = bit_valid;
                    out_bit   = in_bit;
                end
            end
            S_FLUSH: begin
                out_valid = 1'b1;
                out_bit   = ~crc_q[IDX_LAST - idx_q];
            end
            default: begin
                out_valid = 1'b0;
                out_bit   = 1'b0;
            end
        endcase
        busy         = (state_q != S_IDLE);
        result_valid = (state_q == S_DONE);
        crc_ok       = result_valid & (mode_q | (crc_q == RESIDUE));
        crc_err      = result_valid & ~mode_q & (crc_q != RESIDUE);
        overrun      = overrun_q;
        crc_value    = crc_q;
        bit_count    = cnt_q;
    end

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench for usb_crc_engine: a CRC16 unit (unit 0), a CRC5 unit with a
// narrow bit counter (unit 1), and a second CRC16 unit in check mode that
// listens to unit 0's output stream for the loopback case.
module tb_usb_crc_engine;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    // Per-unit stimulus and 1-bit observations (index 0 = CRC16, 1 = CRC5).
    logic st[2], md[2], bv[2], ib[2], dd[2], rdy[2];
    logic ob[2], ov[2], bsy[2], rv[2], ok[2], er[2], ovr[2];
    logic [15:0] g_crc;
    logic [13:0] g_cnt;
    logic [4:0]  f_crc;
    logic [3:0]  f_cnt;

    // Loopback checker.
    logic        c_start, c_bv;
    logic        c_ob, c_ov, c_bsy, c_rv, c_ok, c_er, c_ovr;
    logic [15:0] c_crc;
    logic [13:0] c_cnt;

    assign c_bv = ov[0] & rdy[0];

    usb_crc_engine u_g16 (
        .clock(clock), .reset_n(reset_n), .start(st[0]), .mode_gen(md[0]),
        .bit_valid(bv[0]), .in_bit(ib[0]), .data_done(dd[0]), .out_ready(rdy[0]),
        .out_bit(ob[0]), .out_valid(ov[0]), .busy(bsy[0]), .result_valid(rv[0]),
        .crc_ok(ok[0]), .crc_err(er[0]), .overrun(ovr[0]),
        .crc_value(g_crc), .bit_count(g_cnt)
    );

    usb_crc_engine #(
        .WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C), .CNT_W(4)
    ) u_f5 (
        .clock(clock), .reset_n(reset_n), .start(st[1]), .mode_gen(md[1]),
        .bit_valid(bv[1]), .in_bit(ib[1]), .data_done(dd[1]), .out_ready(rdy[1]),
        .out_bit(ob[1]), .out_valid(ov[1]), .busy(bsy[1]), .result_valid(rv[1]),
        .crc_ok(ok[1]), .crc_err(er[1]), .overrun(ovr[1]),
        .crc_value(f_crc), .bit_count(f_cnt)
    );

    usb_crc_engine u_c16 (
        .clock(clock), .reset_n(reset_n), .start(c_start), .mode_gen(1'b0),
        .bit_valid(c_bv), .in_bit(ob[0]), .data_done(rv[0]), .out_ready(1'b1),
        .out_bit(c_ob), .out_valid(c_ov), .busy(c_bsy), .result_valid(c_rv),
        .crc_ok(c_ok), .crc_err(c_er), .overrun(c_ovr),
        .crc_value(c_crc), .bit_count(c_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;
    int rv_cnt0 = 0;

    always @(posedge clock) if (rv[0]) rv_cnt0 <= rv_cnt0 + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic u_start(input int u, input logic m);
        st[u] = 1'b1;
        md[u] = m;
        step();
        st[u] = 1'b0;
    endtask

    task automatic u_bit(input int u, input logic b, input logic last);
        bv[u] = 1'b1;
        ib[u] = b;
        dd[u] = last;
        step();
        bv[u] = 1'b0;
        dd[u] = 1'b0;
    endtask

    // Feed n bits of v, bit 0 first.
    task automatic u_bits(input int u, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) u_bit(u, v[i], 1'b0);
    endtask

    task automatic u_done(input int u);
        dd[u] = 1'b1;
        step();
        dd[u] = 1'b0;
    endtask

    // Collect w flushed bits in wire order (first bit ends up as MSB of word).
    task automatic u_flush(input int u, input int w, input bit rnd, input bit junk,
                           output logic [15:0] word, output int cyc);
        int got;
        got  = 0;
        cyc  = 0;
        word = '0;
        while (got < w && cyc < 400) begin
            rdy[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bv[u]  = junk;
            ib[u]  = 1'($urandom);
            #1;
            if (ov[u] && rdy[u]) begin
                word = {word[14:0], ob[u]};
                got++;
            end
            step();
            cyc++;
        end
        bv[u]  = 1'b0;
        rdy[u] = 1'b1;
        if (got < w) chk("flush_timeout", got, w);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        int cyc;
        int snap;
        logic [7:0] b;

        for (int i = 0; i < 2; i++) begin
            st[i] = 0; md[i] = 0; bv[i] = 0; ib[i] = 0; dd[i] = 0; rdy[i] = 1;
        end
        c_start = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        chk("rst_flags16", {bsy[0], ov[0], ob[0], rv[0], ok[0], er[0], ovr[0]}, 0);
        chk("rst_crc16", g_crc, 32'hFFFF);
        chk("rst_cnt16", g_cnt, 0);
        chk("rst_crc5", f_crc, 32'h1F);
        reset_n = 1'b1;
        step();

        // CRC16 generate, zero-length packet: flush of ~INIT = all zeros
        u_start(0, 1'b1);
        chk("gen0_busy", bsy[0], 1);
        u_done(0);
        u_flush(0, 16, 1'b0, 1'b0, w, cyc);
        chk("gen0_word", w, 0);
        chk("gen0_cycles", cyc, 16);
        chk("gen0_done", {rv[0], ok[0], er[0]}, 3'b110);
        step();
        chk("gen0_idle", {bsy[0], rv[0]}, 0);

        // data_done in IDLE is ignored
        u_done(0);
        chk("dd_idle", {bsy[0], rv[0]}, 0);

        // CRC16 check on 16 zero bits reaches the residue
        u_start(0, 1'b0);
        bv[0] = 1'b1;
        ib[0] = 1'b0;
        #1;
        chk("chk_no_out", ov[0], 0);
        step();
        bv[0] = 1'b0;
        u_bits(0, 32'h0, 15);
        chk("chk16_crc", g_crc, 32'h800D);
        chk("chk16_cnt", g_cnt, 16);
        u_done(0);
        chk("chk16_ok", {rv[0], ok[0], er[0]}, 3'b110);
        step();

        // One flipped bit must fail
        u_start(0, 1'b0);
        u_bits(0, 32'h0000_0008, 16);
        u_done(0);
        chk("chk16_flip", {rv[0], ok[0], er[0]}, 3'b101);
        step();

        // data_done together with the last bit: bit is included
        u_start(0, 1'b0);
        u_bits(0, 32'h0, 15);
        u_bit(0, 1'b0, 1'b1);
        chk("chk16_coinc", {rv[0], ok[0], er[0]}, 3'b110);
        chk("chk16_coinc_cnt", g_cnt, 16);
        step();

        // Check mode with zero bits compares INIT against RESIDUE
        u_start(0, 1'b0);
        u_done(0);
        chk("chk_empty", {rv[0], ok[0], er[0]}, 3'b101);
        step();

        // Abort mid-ACCUM, then a fresh zero-length generate
        snap = rv_cnt0;
        u_start(0, 1'b1);
        u_bits(0, 32'hA5C3_0F96, 20);
        u_start(0, 1'b1);
        chk("abort_crc", g_crc, 32'hFFFF);
        chk("abort_cnt", g_cnt, 0);
        u_done(0);
        u_flush(0, 16, 1'b0, 1'b0, w, cyc);
        chk("abort_word", w, 0);
        step();
        chk("abort_rv_count", rv_cnt0 - snap, 1);

        // Overrun: junk bits during FLUSH under random backpressure
        u_start(0, 1'b1);
        u_done(0);
        u_flush(0, 16, 1'b1, 1'b1, w, cyc);
        chk("ovr_word", w, 0);
        chk("ovr_set", ovr[0], 1);
        chk("ovr_done", {rv[0], ok[0], er[0]}, 3'b110);
        step();
        chk("ovr_sticky", ovr[0], 1);
        u_start(0, 1'b1);
        chk("ovr_clear", ovr[0], 0);
        u_done(0);
        u_flush(0, 16, 1'b0, 1'b0, w, cyc);
        step();

        // CRC5 generate on ADDR=15h, ENDP=Eh
        u_start(1, 1'b1);
        u_bits(1, 32'h715, 11);
        chk("crc5_reg", f_crc, 32'h08);
        chk("crc5_cnt", f_cnt, 11);
        u_done(1);
        u_flush(1, 5, 1'b0, 1'b0, w, cyc);
        chk("crc5_word", w, 32'h17);
        chk("crc5_gen_done", {rv[1], ok[1], er[1]}, 3'b110);
        step();

        // CRC5 check on the same 16 bits; the 4-bit counter saturates at 15
        u_start(1, 1'b0);
        u_bits(1, 32'h715, 11);
        u_bits(1, 32'h1D, 5);
        chk("crc5_residue", f_crc, 32'h0C);
        chk("crc5_cnt_sat", f_cnt, 15);
        u_done(1);
        chk("crc5_chk_done", {rv[1], ok[1], er[1]}, 3'b110);
        step();

        // Loopback: 64 random bytes, gaps on input, backpressure on flush
        st[0] = 1'b1;
        md[0] = 1'b1;
        c_start = 1'b1;
        step();
        st[0] = 1'b0;
        c_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom_range(0, 255));
            for (int k = 0; k < 8; k++) begin
                repeat ($urandom_range(0, 2)) step();
                u_bit(0, b[k], 1'b0);
            end
        end
        u_done(0);
        u_flush(0, 16, 1'b1, 1'b0, w, cyc);
        chk("lb_gen_done", rv[0], 1);
        chk("lb_gen_cnt", g_cnt, 512);
        step();
        chk("lb_chk_done", {c_rv, c_ok, c_er}, 3'b110);
        chk("lb_chk_cnt", c_cnt, 528);
        step();

        // Asynchronous reset in the middle of FLUSH
        u_start(0, 1'b1);
        u_bits(0, 32'h3, 2);
        u_done(0);
        step();
        step();
        #1;
        chk("rstmid_pre", ov[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_flags", {bsy[0], ov[0], ob[0], rv[0], ok[0], er[0], ovr[0]}, 0);
        chk("rstmid_crc", g_crc, 32'hFFFF);
        chk("rstmid_cnt", g_cnt, 0);
        #1;
        reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/usb_crc_engine.md
Name: usb_crc_engine

Overview:
- Parametrised serial CRC engine for the USB receive/transmit bit paths. It replaces the fixed CRC16-only checker with one block that handles CRC5 (tokens) and CRC16 (data).
- Modes, selected per packet:
  - Generate: pass the data bits through, then flush the complemented CRC.
  - Check: accumulate the data plus received CRC, then compare against the USB residue and report pass/fail.
- Sits between the protocol handler and the bit-stuffer/unstuffer.

Parameters:
- WIDTH, 16: CRC register width. 5 or 16 are the supported values.
- POLY, 16'h8005: generator polynomial without the x^WIDTH term. Use 5'h05 for CRC5.
- INIT, 16'hFFFF: register preset at start. Use all-ones for both CRC widths.
- RESIDUE, 16'h800D: expected register value after a good packet in check mode. Use 5'h0C for CRC5.
- CNT_W, 14: width of the data bit counter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; presets the CRC, latches mode_gen, enters ACCUM
- mode_gen  in  1  1 = generate, 0 = check; sampled only when start=1
- bit_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  serial data, LSB-first per USB field order
- data_done  in  1  one-cycle pulse: last data bit (gen) or last CRC bit (check) has been supplied
- out_ready  in  1  downstream accepts out_bit this cycle
- out_bit  out  1  pass-through data, or CRC bit during FLUSH
- out_valid  out  1  out_bit is valid
- busy  out  1  engine is not in IDLE
- result_valid  out  1  one-cycle pulse on DONE
- crc_ok  out  1  check passed; valid with result_valid
- crc_err  out  1  check failed; valid with result_valid
- overrun  out  1  sticky; bit_valid seen during FLUSH; cleared by start
- crc_value  out  WIDTH  current CRC register
- bit_count  out  CNT_W  bits accumulated since start; saturates at all-ones

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE, crc = INIT, bit_count = 0, flush index = 0.
  - All 1-bit outputs = 0; crc_value = INIT.
- Update rule, applied on each accepted bit:
  - fb = in_bit ^ crc[WIDTH-1].
  - crc <= {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : 0).
  - bit_count increments, saturating.
- States: IDLE, ACCUM, FLUSH, DONE.
- IDLE:
  - bit_valid, data_done and out_ready are ignored; out_valid = 0.
  - start -> ACCUM, with crc = INIT, bit_count = 0, overrun = 0, mode latched.
- ACCUM:
  - bit_valid=1: apply the update rule (accepted bit).
  - Gaps in bit_valid are allowed and hold state (pause).
  - Generate mode: out_bit = in_bit and out_valid = bit_valid, combinational, zero latency. out_ready is ignored in ACCUM.
  - Check mode: out_valid = 0.
  - data_done=1: if bit_valid=1 in the same cycle, that bit is accepted first. Then generate -> FLUSH with index 0; check -> DONE.
- FLUSH (generate only):
  - out_valid = 1, out_bit = ~crc[WIDTH-1-index], i.e. complement, MSB first. crc is frozen.
  - index increments only when out_ready=1.
  - After WIDTH handshakes -> DONE. FLUSH lasts exactly WIDTH cycles when out_ready is held high.
  - bit_valid=1 in FLUSH: the bit is dropped and overrun is set.
- DONE: lasts one cycle, then -> IDLE.
  - result_valid = 1.
  - Check mode: crc_ok = (crc == RESIDUE), crc_err = ~crc_ok.
  - Generate mode: crc_ok = 1, crc_err = 0.
- busy = 1 in ACCUM, FLUSH and DONE.
- Boundary and priority rules:
  - start in any state aborts the current packet and restarts ACCUM. Start has priority over data_done and bit_valid in that cycle; no result_valid is produced for the aborted packet.
  - data_done with zero bits:
    - Generate mode flushes ~INIT.
    - Check mode compares INIT against RESIDUE (fails for USB parameters).
  - data_done outside ACCUM is ignored.
  - bit_count holds at 2^CNT_W-1 once saturated.
  - reset_n low mid-FLUSH drops out_valid immediately (asynchronous).
- Latency:
  - Check mode: result_valid asserts 1 cycle after the data_done cycle.
  - Generate mode: result_valid asserts 1 cycle after the last FLUSH handshake.

Test Plan:
- CRC16 generate, zero-length DATA0 (start, mode_gen=1, data_done with no bits, out_ready=1) -> 16 cycles of out_valid=1, out_bit=0; then result_valid, crc_ok=1.
- CRC16 check: feed 16 zero bits then data_done -> crc_value=16'h800D, result_valid with crc_ok=1. Flip any single bit -> crc_err=1.
- CRC5 instance (WIDTH=5, POLY=5'h05, INIT=5'h1F, RESIDUE=5'h0C):
  - Generate on ADDR=7'h15, ENDP=4'hE (11 bits, LSB-first) -> flushed field 5'b10111 (value 5'h17 on the wire).
  - Check on the same 16 bits -> crc_ok=1.
- Loopback: random 64-byte payload through a generate instance into a check instance, with random bit_valid gaps and random out_ready backpressure -> crc_ok=1, bit_count=512 (generate), 528 (check).
- Abort: start mid-ACCUM after 20 bits, then a fresh zero-length generate -> no result_valid for the first packet; flushed bits all 0.
- Overrun/edge: bit_valid asserted during FLUSH -> overrun=1 and flushed CRC unchanged. data_done coincident with the last bit_valid -> that bit is included (compare with the case where it arrives one cycle earlier). reset_n pulsed mid-FLUSH -> all outputs 0 immediately, crc_value=INIT.
